// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// multicycle_core : FETCH/DECODE/EXEC/MEM/WB MIPS-subset core, req/ack memories
// Revision 1.0
// ============================================================================
module multicycle_core #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] start_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              retire,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_out
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0,  OP_J    = 6'd2,  OP_BEQ = 6'd4,
                          OP_ADDI  = 6'd8,  OP_ANDI = 6'd12, OP_ORI = 6'd13,
                          OP_LW    = 6'd35, OP_SW   = 6'd43;
   localparam logic [5:0] F_SLL = 6'd0,  F_SRL = 6'd2,  F_MULT = 6'd24, F_ADD = 6'd32,
                          F_AND = 6'd36, F_OR  = 6'd37, F_NOR  = 6'd39;
   localparam logic [ADDR_W-1:0] J_MASK = ADDR_W'(32'h03FF_FFFF);

   state_t            state_q, state_d;
   logic              active_q, active_d;
   logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
   logic [31:0]       instr_q, instr_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   logic [5:0]        opcode, funct;
   logic [4:0]        rs, rt, rd, shamt, dest;
   logic [DATA_W-1:0] rs_val, rt_val;
   logic [ADDR_W-1:0] pc_inc, sext_a, j_tgt;
   logic              legal, retire_w;

   assign opcode = instr_q[31:26];
   assign rs     = instr_q[25:21];
   assign rt     = instr_q[20:16];
   assign rd     = instr_q[15:11];
   assign shamt  = instr_q[10:6];
   assign funct  = instr_q[5:0];
   assign dest   = (opcode == OP_RTYPE) ? rd : rt;
   assign pc_inc = pc_q + ADDR_W'(1);
   assign sext_a = ADDR_W'($signed(instr_q[15:0]));
   assign j_tgt  = (pc_inc & ~J_MASK) | (ADDR_W'(instr_q[25:0]) & J_MASK);

   // r0 and out-of-range indices never match, so they read as zero.
   always_comb begin
      rs_val = '0;
      rt_val = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rs == 5'(i)) rs_val = regs_q[i];
         if (rt == 5'(i)) rt_val = regs_q[i];
      end
   end

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_RTYPE: legal = funct inside {F_SLL, F_SRL, F_MULT, F_ADD, F_AND, F_OR, F_NOR};
         OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
         default:  legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      active_d = 1'b1;
      pc_d     = pc_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      res_d    = res_q;
      regs_d   = regs_q;
      retire_w = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (imem_req && imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = rs_val;
            b_d     = rt_val;
            imm_d   = (opcode == OP_ANDI || opcode == OP_ORI) ? DATA_W'(instr_q[15:0])
                                                              : DATA_W'($signed(instr_q[15:0]));
            state_d = legal ? S_EXEC : S_HALT;
         end
         S_EXEC: begin
            case (opcode)
               OP_J: begin
                  pc_d     = j_tgt;
                  retire_w = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_BEQ: begin
                  pc_d     = (a_q == b_q) ? pc_inc + sext_a : pc_inc;
                  retire_w = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_LW, OP_SW: begin
                  addr_d  = ADDR_W'(a_q) + sext_a;
                  state_d = S_MEM;
               end
               OP_ADDI: begin res_d = a_q + imm_q; state_d = S_WB; end
               OP_ANDI: begin res_d = a_q & imm_q; state_d = S_WB; end
               OP_ORI:  begin res_d = a_q | imm_q; state_d = S_WB; end
               default: begin
                  case (funct)
                     F_ADD:   res_d = a_q + b_q;
                     F_AND:   res_d = a_q & b_q;
                     F_OR:    res_d = a_q | b_q;
                     F_NOR:   res_d = ~(a_q | b_q);
                     F_MULT:  res_d = a_q * b_q;
                     F_SLL:   res_d = b_q << shamt;
                     default: res_d = b_q >> shamt;
                  endcase
                  state_d = S_WB;
               end
            endcase
         end
         S_MEM: begin
            if (dmem_req && dmem_ack) begin
               if (opcode == OP_SW) begin
                  pc_d     = pc_inc;
                  retire_w = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  res_d   = dmem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            for (int i = 1; i < NUM_REGS; i++) begin
               if (dest == 5'(i)) regs_d[i] = res_q;
            end
            pc_d     = pc_inc;
            retire_w = 1'b1;
            state_d  = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end

   // active_q holds requests low for the cycle after reset so in-flight reqs drop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         active_q <= 1'b0;
         pc_q     <= start_pc;
         addr_q   <= '0;
         instr_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         res_q    <= '0;
         regs_q   <= '{default: '0};
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         res_q    <= res_d;
         regs_q   <= regs_d;
      end
   end

   assign imem_req   = active_q && (state_q == S_FETCH);
   assign imem_addr  = imem_req ? pc_q : '0;
   assign dmem_req   = active_q && (state_q == S_MEM);
   assign dmem_we    = dmem_req && (opcode == OP_SW);
   assign dmem_addr  = dmem_req ? addr_q : '0;
   assign dmem_wdata = dmem_req ? b_q : '0;
   assign retire     = retire_w && !reset;
   assign halted     = active_q && (state_q == S_HALT);
   assign pc_out     = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// Scoreboard bench for multicycle_core: directed programs, queued expectations,
// a negedge monitor checks retires (latency, next pc) and every data access.
module tb_multicycle_core;
   localparam logic [31:0] HALT_W = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] start_pc = 32'd5;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;

   logic [31:0] imem [256];
   logic [31:0] dmem [256];
   logic        imem_hold = 1'b0;
   logic        force_ack = 1'b0;
   int          dcnt = 0;
   int          errors = 0;
   int          checks = 0;

   typedef struct { logic [31:0] npc; int cyc; } ret_t;
   typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_t;
   ret_t ret_q[$];
   mem_t mem_q[$];

   always #5 clk = ~clk;

   multicycle_core #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(32)) dut (
      .clk(clk), .reset(reset), .start_pc(start_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .retire(retire), .halted(halted), .pc_out(pc_out)
   );

   // Memory models: stores to word 0x16 wait 3 cycles, everything else is zero-wait.
   assign imem_ack   = (imem_req && !imem_hold) || force_ack;
   assign imem_rdata = imem[imem_addr[7:0]];
   assign dmem_ack   = dmem_req && (dcnt >= ((dmem_we && dmem_addr == 32'h16) ? 3 : 0));
   assign dmem_rdata = dmem[dmem_addr[7:0]];

   always @(posedge clk) begin
      if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
      else                       dcnt <= 0;
      if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ity(input int op, input int rs, input int rt, input int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] rty(input int rs, input int rt, input int rd,
                                       input int sh, input int fn);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
   endfunction

   task automatic put(input int addr, input logic [31:0] ins, input logic [31:0] npc, input int cyc);
      imem[addr] = ins;
      ret_q.push_back(ret_t'{npc, cyc});
   endtask

   task automatic st(input logic [31:0] addr, input logic [31:0] data);
      mem_q.push_back(mem_t'{1'b1, addr, data});
   endtask

   task automatic ld(input logic [31:0] addr);
      mem_q.push_back(mem_t'{1'b0, addr, 32'h0});
   endtask

   // Monitor: pops the scoreboard whenever the DUT retires or touches data memory.
   initial begin
      int          n = 0;
      logic        prev_req = 1'b0;
      logic        pend = 1'b0;
      logic [31:0] pend_pc = '0;
      ret_t        r;
      mem_t        m;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("next_pc", pc_out, pend_pc);
            pend = 1'b0;
         end
         if (imem_req && !prev_req) n = 1;
         else                       n = n + 1;
         prev_req = imem_req;
         if (retire) begin
            if (ret_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_retire: retire=1 at pc %h, expected none", pc_out);
            end else begin
               r = ret_q.pop_front();
               chk("cycles", 32'(n), 32'(r.cyc));
               pend    = 1'b1;
               pend_pc = r.npc;
            end
         end
         if (dmem_req) begin
            if (mem_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_dmem: addr %h we %b, expected no access", dmem_addr, dmem_we);
            end else begin
               m = mem_q[0];
               chk("dmem_we", {31'd0, dmem_we}, {31'd0, m.we});
               chk("dmem_addr", dmem_addr, m.addr);
               if (m.we) chk("dmem_wdata", dmem_wdata, m.data);
               if (dmem_ack) void'(mem_q.pop_front());
            end
         end
      end
   end

   task automatic fill();
      for (int i = 0; i < 256; i++) imem[i] = HALT_W;
   endtask

   task automatic reset_and_check(input logic [31:0] pc);
      reset    = 1'b1;
      start_pc = pc;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {24'd0, imem_req, dmem_req, dmem_we, retire, halted,
                            |imem_addr, |dmem_addr, |dmem_wdata}, 32'h0);
      chk("reset_pc_out", pc_out, pc);
   endtask

   task automatic wait_first_fetch(input logic [31:0] pc);
      int k = 0;
      while (!imem_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("first_fetch_req", {31'd0, imem_req}, 32'd1);
      chk("first_fetch_addr", imem_addr, pc);
   endtask

   task automatic wait_halt_and_idle();
      int k = 0;
      logic bad = 1'b0;
      while (!halted && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("halt_reached", {31'd0, halted}, 32'd1);
      @(negedge clk);
      chk("retires_left", 32'(ret_q.size()), 32'd0);
      chk("dmem_left", 32'(mem_q.size()), 32'd0);
      repeat (10) begin
         @(negedge clk);
         if (imem_req || dmem_req || retire || !halted) bad = 1'b1;
      end
      chk("halt_idle", {31'd0, bad}, 32'd0);
   endtask

   initial begin
      logic [31:0] alu_exp [7];
      alu_exp = '{32'h15, 32'h2, 32'h13, 32'hFFFF_FFEC, 32'h36, 32'h120, 32'h1};
      for (int i = 0; i < 256; i++) dmem[i] = 32'h0;

      // Program A: ALU, loads/stores, r0 write, NOP, halt on opcode 63.
      fill();
      reset_and_check(32'd5);
      put(5,  ity(8, 0, 1, -3), 6, 4);
      put(6,  ity(43, 0, 1, 0), 7, 4);      st(32'h0, 32'hFFFF_FFFD);
      put(7,  ity(8, 0, 1, 32'h12), 8, 4);
      put(8,  ity(8, 0, 2, 3), 9, 4);
      put(9,  rty(1, 2, 3, 0, 32), 10, 4);
      put(10, rty(1, 2, 4, 0, 36), 11, 4);
      put(11, rty(1, 2, 5, 0, 37), 12, 4);
      put(12, rty(1, 2, 6, 0, 39), 13, 4);
      put(13, rty(1, 2, 7, 0, 24), 14, 4);
      put(14, rty(0, 1, 8, 4, 0), 15, 4);
      put(15, rty(0, 1, 9, 4, 2), 16, 4);
      for (int k = 0; k < 7; k++) begin
         put(16 + k, ity(43, 0, 3 + k, 32'h20 + k), 32'(17 + k), 4);
         st(32'(32'h20 + k), alu_exp[k]);
      end
      put(23, ity(43, 1, 2, 4), 24, 7);     st(32'h16, 32'h3);
      put(24, ity(35, 1, 3, 4), 25, 5);     ld(32'h16);
      put(25, ity(43, 0, 3, 32'h30), 26, 4); st(32'h30, 32'h3);
      put(26, ity(8, 0, 0, 7), 27, 4);
      put(27, ity(43, 0, 0, 32'h31), 28, 4); st(32'h31, 32'h0);
      put(28, ity(12, 1, 10, 32'hFFF0), 29, 4);
      put(29, ity(13, 0, 11, 32'h8000), 30, 4);
      put(30, ity(8, 6, 12, 32'h14), 31, 4);
      put(31, ity(43, 0, 10, 32'h32), 32, 4); st(32'h32, 32'h10);
      put(32, ity(43, 0, 11, 32'h33), 33, 4); st(32'h33, 32'h8000);
      put(33, ity(43, 0, 12, 32'h34), 34, 4); st(32'h34, 32'h0);
      put(34, 32'h0, 35, 4);
      imem[35] = HALT_W;
      reset = 1'b0;
      wait_first_fetch(32'd5);
      wait_halt_and_idle();

      // Program B: branches and jump, halt on an unlisted funct.
      fill();
      reset_and_check(32'd10);
      put(10,    ity(4, 0, 0, -2), 32'd9, 3);
      put(9,     {6'd2, 26'h40}, 32'h40, 3);
      put(32'h40, ity(8, 0, 1, 1), 32'h41, 4);
      put(32'h41, ity(4, 0, 1, 5), 32'h42, 3);
      put(32'h42, ity(4, 1, 1, 3), 32'h46, 3);
      imem[32'h46] = rty(0, 0, 0, 0, 1);
      reset = 1'b0;
      wait_first_fetch(32'd10);
      wait_halt_and_idle();

      // Program C: reset while a fetch waits, then a stray ack with req low.
      fill();
      imem_hold = 1'b1;
      reset_and_check(32'h50);
      reset = 1'b0;
      wait_first_fetch(32'h50);
      repeat (2) @(negedge clk);
      chk("fetch_waiting_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_waiting_addr", imem_addr, 32'h50);
      reset    = 1'b1;
      start_pc = 32'h60;
      @(negedge clk);
      chk("req_drop_after_reset", {31'd0, imem_req}, 32'd0);
      imem[0] = ity(43, 0, 0, 32'h77);
      put(32'h60, ity(8, 0, 1, 5), 32'h61, 4);
      put(32'h61, ity(43, 0, 1, 32'h35), 32'h62, 4); st(32'h35, 32'h5);
      imem_hold = 1'b0;
      @(negedge clk);
      chk("reset_pc_reload", pc_out, 32'h60);
      reset     = 1'b0;
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      chk("late_ack_ignored_req", {31'd0, imem_req}, 32'd1);
      chk("late_ack_ignored_addr", imem_addr, 32'h60);
      wait_halt_and_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
